i2c_mem_slave_burst: RTL and testbench
======================================

# i2c_mem_slave_burst

Parametrised I2C memory slave, the next generation of the team's single-byte memory slave. It answers a configurable 7-bit device address and supports multi-byte burst writes and reads with an auto-incrementing, wrapping word pointer. It handles repeated START and arbitrary STOP, and detects START/STOP from real SCL/SDA edges rather than a free-running pulse counter. It sits on the shared `scl`/`sda` bus beside the I2C master as the target memory device.

## Interface
- DEV_ADDR, 7'h50, 7-bit device address the block answers.
- MEM_DEPTH, 128, number of 8-bit words; power of two, 2..256.
- PTR_W, $clog2(MEM_DEPTH), pointer width (derived, not overridden).
- clk  in  1  system clock; must be ≥ 8× SCL frequency.
- rst  in  1  asynchronous, active-high reset.
- scl  in  1  I2C clock from master.
- sda  inout  1  open-drain data: driven 0 when `sda_oe`, else `1'bz`; never driven 1.
- busy  out  1  high from an address match until STOP, or until the next START addresses another device.
- done  out  1  one-cycle pulse on STOP ending a transaction that matched DEV_ADDR.
- ack_err  out  1  one-cycle pulse on bus error: START or STOP detected with 1..7 bits of a byte shifted.

## Operation
- `scl`/`sda` pass through 2-flop synchronisers; edges are detected on the synchronised values (`scl_rise`, `scl_fall`).
- START: synchronised sda falls while scl is high. STOP: sda rises while scl is high. Both are honoured in every state; repeated START re-enters ADDR.
- Data bits are sampled on `scl_rise`, MSB first. The slave changes `sda_oe` only on `scl_fall`.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On a match `{DEV_ADDR,rw}`, go to ADDR_ACK. On a mismatch, go to WAIT_STOP without acknowledging.
  - ADDR_ACK: drive 0 for one SCL period. Then rw=1 → RD_DATA; rw=0 → PTR.
  - PTR: the first write byte loads the pointer as `ptr <= byte[PTR_W-1:0]`; upper bits are ignored. Then PTR_ACK.
  - PTR_ACK: drive 0 for one SCL period, then WR_DATA.
  - WR_DATA: shift 8 bits. Write to `mem[ptr]` 1 clk after the 8th `scl_rise`, and `ptr++` in the same cycle. Then WR_ACK.
  - WR_ACK: drive 0 for one SCL period, then WR_DATA.
  - RD_DATA: on entry (`scl_fall`), load `shreg <= mem[ptr]` and `ptr++`. Drive `sda_oe = ~shreg[7]` per bit. After the 8th bit, release sda and go to RD_ACK.
  - RD_ACK: sample master ACK on `scl_rise`. ACK (0) → RD_DATA. NACK (1) → WAIT_STOP.
  - WAIT_STOP: sda released. Wait for STOP (→ IDLE) or START (→ ADDR).
- Pointer wraps MEM_DEPTH-1 → 0. The pointer persists across transactions, so a read without a pointer write continues from the last pointer.
- Reset:
  - Asynchronous: state=IDLE, `sda_oe`=0, ptr=0, busy=0, done=0, ack_err=0.
  - Memory is initialised to `mem[i]=i[7:0]` on the first clock edge after reset deasserts; this is a loop, so a synchronous init is allowed.
- Simultaneous events: STOP/START take priority over any bit or edge event in the same cycle. An in-progress memory write completes only if its commit cycle has already been reached.

## Timing
- Input-to-edge detect latency: 2 clk (synchroniser) + 1 clk (edge register).
- ACK / data drive: `sda_oe` updates 1 clk after `scl_fall` is detected, i.e. 4 clk after the true SCL fall. It is released 4 clk after the true fall that ends the ACK bit.
- `done` and `ack_err` rise 1 clk after the STOP/START detect cycle and are high for exactly 1 clk.
- `busy` rises with the ADDR_ACK entry and falls with `done`.

## Structure
- Package `i2c_pkg`: state enum `i2c_slv_state_t`, START/STOP and ACK/NACK constants, shared with the master.
- One natural sub-module: `i2c_bus_sync` (2-flop synchronisers, edge and START/STOP detect), reused by the master.
- Memory is inferred as a register array inside the top.

## Test plan
- Reset, then write burst: addr 0xA0, ptr 0x10, data 0xAA,0xBB,0xCC, STOP → 5 ACKs; mem[0x10..0x12]=AA,BB,CC; one `done` pulse.
- Repeated-START read wrap (MEM_DEPTH=128): write ptr 0x7E, Sr, 0xA1, read 4 bytes with master ACK,ACK,ACK,NACK → data 0x7E,0x7F,0x00,0x01; sda released after NACK.
- Address mismatch: 0xA2 then data 0x55 → no ACK (sda stays high); memory unchanged; no `done`; `busy`=0.
- Bus error: STOP after 3 bits of a data byte → `ack_err` 1-clk pulse, FSM in IDLE, target word unchanged.
- Async reset mid-read: assert `rst` while the slave drives 0 → sda goes Z immediately; ptr=0; next read returns 0x00.
- Pointer persistence: write ptr 0x05, STOP, then a fresh read of 2 bytes → 0x05,0x06.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, bus-condition codes and ACK levels.
// Used by the memory slave and the bus master.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_slv_state_t;

    localparam logic [1:0] I2C_COND_NONE  = 2'b00;
    localparam logic [1:0] I2C_COND_START = 2'b01;
    localparam logic [1:0] I2C_COND_STOP  = 2'b10;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

    function automatic logic [7:0] i2c_addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers on SCL/SDA, registered SCL edge pulses and START/STOP
// detection. All outputs are aligned to the same clock cycle.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       sda_lvl,
    output logic [1:0] cond
);

    logic       scl_m_q, scl_s_q, scl_p_q;
    logic       sda_m_q, sda_s_q, sda_p_q;
    logic       rise_d, rise_q, fall_d, fall_q;
    logic [1:0] cond_d, cond_q;

    always_comb begin
        rise_d = scl_s_q & ~scl_p_q;
        fall_d = ~scl_s_q & scl_p_q;
        cond_d = I2C_COND_NONE;
        // SDA may only change with SCL stably high for a bus condition
        if (scl_s_q && scl_p_q && sda_p_q && !sda_s_q) begin
            cond_d = I2C_COND_START;
        end else if (scl_s_q && scl_p_q && !sda_p_q && sda_s_q) begin
            cond_d = I2C_COND_STOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_m_q <= 1'b1;
            scl_s_q <= 1'b1;
            scl_p_q <= 1'b1;
            sda_m_q <= 1'b1;
            sda_s_q <= 1'b1;
            sda_p_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cond_q  <= I2C_COND_NONE;
        end else begin
            scl_m_q <= scl_i;
            scl_s_q <= scl_m_q;
            scl_p_q <= scl_s_q;
            sda_m_q <= sda_i;
            sda_s_q <= sda_m_q;
            sda_p_q <= sda_s_q;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cond_q  <= cond_d;
        end
    end

    assign scl_rise = rise_q;
    assign scl_fall = fall_q;
    assign sda_lvl  = sda_p_q;
    assign cond     = cond_q;

endmodule

// File: rtl/i2c_mem_slave_burst.sv
// I2C memory slave with burst read/write and an auto-incrementing wrapping pointer.
// The pointer persists across transactions; memory comes up as mem[i] = i.
module i2c_mem_slave_burst
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         MEM_DEPTH = 128,
    localparam int        PTR_W     = $clog2(MEM_DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    inout  wire  sda,
    output logic busy,
    output logic done,
    output logic ack_err
);

    i2c_slv_state_t state_q, state_d;

    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             rw_q, rw_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             wr_en_q, wr_en_d;
    logic             init_q;

    logic [7:0] mem [MEM_DEPTH];

    logic       scl_rise, scl_fall, sda_lvl;
    logic [1:0] cond;
    logic       start_det, stop_det, byte_done, addr_hit, rd_load;
    logic [7:0] rd_byte;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl),
        .sda_i    (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_lvl  (sda_lvl),
        .cond     (cond)
    );

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign start_det = (cond == I2C_COND_START);
    assign stop_det  = (cond == I2C_COND_STOP);
    assign byte_done = (cnt_q == I2C_BYTE_BITS);
    assign addr_hit  = (shreg_q == i2c_addr_byte(DEV_ADDR, shreg_q[0]));
    assign rd_byte   = mem[ptr_q];
    assign rd_load   = scl_fall && ((state_q == ST_ADDR_ACK && rw_q) ||
                                    (state_q == ST_RD_ACK && ack_q == I2C_ACK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ST_ADDR;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR:     if (byte_done) state_d = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
                ST_ADDR_ACK: state_d = rw_q ? ST_RD_DATA : ST_PTR;
                ST_PTR:      if (byte_done) state_d = ST_PTR_ACK;
                ST_PTR_ACK:  state_d = ST_WR_DATA;
                ST_WR_DATA:  if (byte_done) state_d = ST_WR_ACK;
                ST_WR_ACK:   state_d = ST_WR_DATA;
                ST_RD_DATA:  if (byte_done) state_d = ST_RD_ACK;
                ST_RD_ACK:   state_d = (ack_q == I2C_NACK) ? ST_WAIT_STOP : ST_RD_DATA;
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        wr_en_d   = 1'b0;
        if (wr_en_q) ptr_d = ptr_q + PTR_W'(1);
        if (start_det || stop_det) begin
            // the SCL pulse carrying the condition was counted as a rise, so cnt-1 bits were shifted
            ack_err_d = (cnt_q >= 4'd2);
            done_d    = stop_det && busy_q;
            if (stop_det) busy_d = 1'b0;
            sda_oe_d  = 1'b0;
            cnt_d     = '0;
        end else begin
            if (scl_rise) begin
                case (state_q)
                    ST_ADDR, ST_PTR, ST_WR_DATA: begin
                        shreg_d = {shreg_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                        wr_en_d = (state_q == ST_WR_DATA) && (cnt_q == I2C_BYTE_BITS - 4'd1);
                    end
                    ST_RD_DATA: cnt_d = cnt_q + 4'd1;
                    ST_RD_ACK:  ack_d = sda_lvl;
                    default: ;
                endcase
            end
            if (scl_fall) begin
                case (state_q)
                    ST_ADDR: if (byte_done) begin
                        cnt_d = '0;
                        if (addr_hit) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shreg_q[0];
                        end else begin
                            busy_d   = 1'b0;
                        end
                    end
                    ST_PTR: if (byte_done) begin
                        ptr_d    = shreg_q[PTR_W-1:0];
                        sda_oe_d = 1'b1;
                        cnt_d    = '0;
                    end
                    ST_WR_DATA: if (byte_done) begin
                        sda_oe_d = 1'b1;
                        cnt_d    = '0;
                    end
                    ST_RD_DATA: begin
                        if (byte_done) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                        end
                    end
                    default: sda_oe_d = 1'b0;
                endcase
                if (rd_load) begin
                    shreg_d  = rd_byte;
                    sda_oe_d = ~rd_byte[7];
                    ptr_d    = ptr_q + PTR_W'(1);
                    cnt_d    = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            wr_en_q   <= 1'b0;
            init_q    <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            wr_en_q   <= wr_en_d;
            init_q    <= 1'b0;
        end
    end

    // Write commits one cycle after the last data bit, using the pointer before its increment
    always_ff @(posedge clk) begin
        if (init_q) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= i[7:0];
        end else if (wr_en_q) begin
            mem[ptr_q] <= shreg_q;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_mem_slave_burst.sv
// Bench for i2c_mem_slave_burst: bit-banged I2C master, reference memory model
// and a scoreboard of expected ACK bits and read bytes.
module tb_i2c_mem_slave_burst;

    localparam int DEPTH = 128;
    localparam int QT    = 40;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic scl_r = 1'b1;
    logic m_oe  = 1'b0;
    wire  sda;
    logic busy, done, ack_err;

    int n_chk  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_aerr = 0;

    logic [7:0] m_mem [DEPTH];
    logic [6:0] m_ptr;
    logic [7:0] sb_q [$];

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_mem_slave_burst #(.DEV_ADDR(7'h50), .MEM_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl_r),
        .sda     (sda),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err)
    );

    always @(posedge clk) begin
        if (done)    n_done <= n_done + 1;
        if (ack_err) n_aerr <= n_aerr + 1;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_chk(input string tag, input logic [7:0] got);
        logic [7:0] e;
        if (sb_q.size() == 0) e = ~got;
        else                  e = sb_q.pop_front();
        chk(tag, got, e);
    endtask

    task automatic model_init;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'(i);
        m_ptr = '0;
    endtask

    // Entered QT after an SCL fall; leaves QT after the next fall.
    task automatic clk_bit(input logic drive_low, output logic smp);
        m_oe = drive_low;
        #QT; scl_r = 1'b1;
        #QT; smp = sda;
        #QT; scl_r = 1'b0;
        #QT;
    endtask

    task automatic bus_start;
        if (scl_r == 1'b0) begin
            m_oe = 1'b0;
            #QT; scl_r = 1'b1;
            #QT;
        end
        m_oe = 1'b1;
        #QT; scl_r = 1'b0;
        #QT;
    endtask

    task automatic bus_stop;
        m_oe = 1'b1;
        #QT; scl_r = 1'b1;
        #QT; m_oe = 1'b0;
        #(2*QT);
    endtask

    task automatic wb(input logic [7:0] b, input logic exp_ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(~b[i], s);
        sb_q.push_back(8'(exp_ack));
        clk_bit(1'b0, s);
        sb_chk("ack", 8'(s));
    endtask

    task automatic wdata(input logic [7:0] b);
        m_mem[m_ptr] = b;
        m_ptr = m_ptr + 7'd1;
        wb(b, 1'b0);
    endtask

    task automatic rb(input logic master_ack);
        logic       s;
        logic [7:0] d;
        sb_q.push_back(m_mem[m_ptr]);
        m_ptr = m_ptr + 7'd1;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b0, s);
            d[i] = s;
        end
        sb_chk("rd", d);
        clk_bit(master_ack, s);
    endtask

    task automatic read_at(input logic [7:0] p, input int n);
        bus_start;
        wb(8'hA0, 1'b0);
        wb(p, 1'b0);
        m_ptr = p[6:0];
        bus_start;
        wb(8'hA1, 1'b0);
        for (int i = 0; i < n; i++) rb(i != n - 1);
        #QT;
        chk("rel", 8'(sda), 8'd1);
        bus_stop;
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL timeout at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        int  d0, e0;
        logic s;
        model_init();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_sda",  8'(sda),     8'd1);
        chk("rst_busy", 8'(busy),    8'd0);
        chk("rst_done", 8'(done),    8'd0);
        chk("rst_aerr", 8'(ack_err), 8'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // burst write of three bytes at 0x10
        d0 = n_done;
        bus_start;
        wb(8'hA0, 1'b0);
        wb(8'h10, 1'b0);
        m_ptr = 7'h10;
        wdata(8'hAA);
        wdata(8'hBB);
        wdata(8'hCC);
        chk("busy_wr", 8'(busy), 8'd1);
        bus_stop;
        chk("done_wr", 8'(n_done - d0), 8'd1);
        chk("busy_end", 8'(busy), 8'd0);
        read_at(8'h10, 3);

        // read across the top of memory
        read_at(8'h7E, 4);

        // foreign address: no ACK, no write, no done
        d0 = n_done;
        bus_start;
        wb(8'hA2, 1'b1);
        wb(8'h55, 1'b1);
        chk("busy_miss", 8'(busy), 8'd0);
        bus_stop;
        chk("done_miss", 8'(n_done - d0), 8'd0);
        read_at(8'h55, 1);

        // STOP three bits into a data byte
        e0 = n_aerr;
        bus_start;
        wb(8'hA0, 1'b0);
        wb(8'h20, 1'b0);
        m_ptr = 7'h20;
        for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
        bus_stop;
        chk("aerr", 8'(n_aerr - e0), 8'd1);
        chk("busy_err", 8'(busy), 8'd0);
        read_at(8'h20, 1);

        // pointer set in one transaction, read in the next
        bus_start;
        wb(8'hA0, 1'b0);
        wb(8'h05, 1'b0);
        m_ptr = 7'h05;
        bus_stop;
        bus_start;
        wb(8'hA1, 1'b0);
        rb(1'b1);
        rb(1'b0);
        #QT;
        chk("rel_p", 8'(sda), 8'd1);
        bus_stop;

        // reset while the slave is driving a data bit
        bus_start;
        wb(8'hA1, 1'b0);
        #QT;
        chk("drv", 8'(sda), 8'(m_mem[m_ptr][7]));
        rst = 1'b1;
        #1;
        chk("rst_z", 8'(sda), 8'd1);
        chk("rst_busy2", 8'(busy), 8'd0);
        @(negedge clk);
        scl_r = 1'b1;
        m_oe  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_init();
        repeat (4) @(negedge clk);
        bus_start;
        wb(8'hA1, 1'b0);
        rb(1'b0);
        bus_stop;
        chk("sb_empty", 8'(sb_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
